// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared game-level definitions. Holds the game-state codes
//                driven by the top-level game FSM and the state encoding of
//                the beam-weapon FSM.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

   // Game-state codes as driven by the game-state FSM
   typedef enum logic [1:0] {
      GS_PRESS_START = 2'd0,
      GS_PLAYING     = 2'd1,
      GS_GAMEOVER    = 2'd2,
      GS_CLEAR       = 2'd3
   } game_state_e;

   // Beam-weapon FSM encoding
   localparam logic [1:0] c_ST_IDLE   = 2'd0;
   localparam logic [1:0] c_ST_READY  = 2'd1;
   localparam logic [1:0] c_ST_FIRING = 2'd2;
   localparam logic [1:0] c_ST_LOCKED = 2'd3;

endpackage : game_pkg
`default_nettype wire

// File: rtl/energy_bar_rgb.sv
`default_nettype none
// ============================================================================
//  Module      : energy_bar_rgb
//  Description : Combinational mapping of an EW-bit energy value onto a
//                12-bit 4:4:4 RGB bar colour. The top 12 bits of the energy
//                are used: colour fades white -> yellow -> red-ish as energy
//                falls. A locked meter is always shown solid red.
//  Ports       : i_energy [EW-1:0] - energy value (EW >= 12)
//                i_locked          - force lockout colour 12'hF00
//                o_rgb    [11:0]   - {R,G,B} nibbles
//  Revision    : 1.0 - initial release
// ============================================================================
module energy_bar_rgb #(
   parameter int EW = 12
) (
   input  logic [EW-1:0] i_energy,
   input  logic          i_locked,
   output logic [11:0]   o_rgb
);

   logic [11:0] w_e;
   logic [3:0]  w_r;
   logic [3:0]  w_g;
   logic [3:0]  w_b;

   assign w_e = i_energy[EW-1:EW-12];

   // Each channel saturates to F once any more significant nibble is set
   assign w_r = (w_e[11:4] != 8'd0) ? 4'hF : w_e[3:0];
   assign w_g = (w_e[11:8] != 4'd0) ? 4'hF : w_e[7:4];
   assign w_b = w_e[11:8];

   assign o_rgb = i_locked ? 12'hF00 : {w_r, w_g, w_b};

endmodule : energy_bar_rgb
`default_nettype wire

// File: rtl/beam_energy_controller.sv
`default_nettype none
// ============================================================================
//  Module      : beam_energy_controller
//  Description : Beam-weapon energy reservoir. Drains while the player fires,
//                recharges after an idle delay, and locks the weapon out after
//                full depletion until the reservoir refills to LOCK_LEVEL.
//                Non-playing game states override the FSM.
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                i_state   [1:0]      - game state (0 start,1 play,2 over,3 clear)
//                i_fire               - beam request (level)
//                i_plane_h [H_W-1:0]  - player x position
//                o_beam_enable        - beam active
//                o_beam_h  [H_W-1:0]  - beam x, 0 when inactive
//                o_energy  [EW-1:0]   - current reservoir
//                o_locked             - depletion lockout
//                o_power_rgb [11:0]   - HUD bar colour 4:4:4
//  Revision    : 1.0 - initial release
// ============================================================================
module beam_energy_controller
   import game_pkg::*;
#(
   parameter int EW             = 12,
   parameter int H_W            = 10,
   parameter int DRAIN          = 1,
   parameter int RECHARGE       = 1,
   parameter int RECHARGE_DELAY = 64,
   parameter int LOCK_LEVEL     = 2 ** (EW - 2),
   parameter int BEAM_OFFSET    = 10
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [1:0]     i_state,
   input  logic           i_fire,
   input  logic [H_W-1:0] i_plane_h,
   output logic           o_beam_enable,
   output logic [H_W-1:0] o_beam_h,
   output logic [EW-1:0]  o_energy,
   output logic           o_locked,
   output logic [11:0]    o_power_rgb
);

   localparam int             c_DW       = $clog2(RECHARGE_DELAY + 1);
   localparam logic [EW:0]    c_FULL     = {1'b0, {EW{1'b1}}};
   localparam logic [EW:0]    c_DRAIN    = (EW + 1)'(DRAIN);
   localparam logic [EW:0]    c_RECHARGE = (EW + 1)'(RECHARGE);
   localparam logic [EW-1:0]  c_LOCK     = EW'(LOCK_LEVEL);
   localparam logic [c_DW-1:0] c_DELAY   = c_DW'(RECHARGE_DELAY);
   localparam logic [H_W-1:0] c_OFFSET   = H_W'(BEAM_OFFSET);

   logic [1:0]      r_state;
   logic [EW-1:0]   r_energy;
   logic [c_DW-1:0] r_delay;

   logic [1:0]      w_state_nxt;
   logic [EW-1:0]   w_energy_nxt;
   logic [c_DW-1:0] w_delay_nxt;

   logic [EW:0]     w_sum;
   logic [EW:0]     w_diff;
   logic [EW-1:0]   w_recharged;
   logic [EW-1:0]   w_drained;
   logic            w_delay_done;

   // One bit of headroom catches overflow / underflow before saturation
   assign w_sum       = {1'b0, r_energy} + c_RECHARGE;
   assign w_diff      = {1'b0, r_energy} - c_DRAIN;
   assign w_recharged = (w_sum > c_FULL) ? {EW{1'b1}} : w_sum[EW-1:0];
   assign w_drained   = w_diff[EW] ? {EW{1'b0}} : w_diff[EW-1:0];
   assign w_delay_done = (r_delay == c_DELAY);

   always_comb begin
      w_state_nxt  = r_state;
      w_energy_nxt = r_energy;
      w_delay_nxt  = r_delay;

      if (i_state != GS_PLAYING) begin
         w_state_nxt = c_ST_IDLE;
         w_delay_nxt = '0;
         if (i_state == GS_PRESS_START) begin
            w_energy_nxt = {EW{1'b1}};
         end else if (i_state == GS_CLEAR) begin
            w_energy_nxt = '0;
         end
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               w_state_nxt = c_ST_READY;
            end
            c_ST_READY: begin
               if (i_fire && (r_energy != '0)) begin
                  // Firing takes priority over a pending recharge
                  w_state_nxt = c_ST_FIRING;
                  w_delay_nxt = '0;
               end else if (w_delay_done) begin
                  w_energy_nxt = w_recharged;
               end else begin
                  w_delay_nxt = r_delay + c_DW'(1);
               end
            end
            c_ST_FIRING: begin
               if (!i_fire) begin
                  w_state_nxt = c_ST_READY;
                  w_delay_nxt = '0;
               end else begin
                  w_energy_nxt = w_drained;
                  if (w_drained == '0) begin
                     w_state_nxt = c_ST_LOCKED;
                     w_delay_nxt = '0;
                  end
               end
            end
            c_ST_LOCKED: begin
               // Delay counter survives the exit so recharge keeps running
               if (w_delay_done) begin
                  w_energy_nxt = w_recharged;
               end else begin
                  w_delay_nxt = r_delay + c_DW'(1);
               end
               if (r_energy >= c_LOCK) begin
                  w_state_nxt = c_ST_READY;
               end
            end
            default: begin
               w_state_nxt = c_ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= c_ST_IDLE;
         r_energy <= {EW{1'b1}};
         r_delay  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_energy <= w_energy_nxt;
         r_delay  <= w_delay_nxt;
      end
   end

   assign o_beam_enable = (r_state == c_ST_FIRING);
   assign o_locked      = (r_state == c_ST_LOCKED);
   assign o_energy      = r_energy;
   assign o_beam_h      = o_beam_enable ? (i_plane_h + c_OFFSET) : '0;

   energy_bar_rgb #(
      .EW (EW)
   ) u_energy_bar_rgb (
      .i_energy (r_energy),
      .i_locked (o_locked),
      .o_rgb    (o_power_rgb)
   );

endmodule : beam_energy_controller
`default_nettype wire
